// File: rtl/imem_loader.sv
// imem_loader: packs a host byte stream (16-bit word count, then bytes) into little-endian 32-bit instruction writes.
// Latency: write pulse 1 cycle after the 4th byte of a word; one word per 5 cycles sustained; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
// Backpressure: in_ready is registered from state only; bytes offered while in_ready=0 must be held by the host.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`else
        S_FINISH,
`endif
        S_DONE,
        S_ERROR
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_FINISH;
`endif

    state_t      state;
    state_t      nxt;
    logic [15:0] len;
    logic [15:0] len_new;
    logic [15:0] count_next;
    logic [1:0]  byte_cnt;
    logic        xfer;
    logic        ready_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xsum;
`endif

    assign xfer       = in_valid & in_ready;
    assign len_new    = {in_data, len[7:0]};
    assign count_next = 16'(words_loaded) + 16'd1;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_new > 16'(DEPTH))  nxt = S_ERROR;
                    else if (len_new == 16'd0) nxt = S_TAIL;
                    else                       nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && byte_cnt == 2'd3) nxt = S_WRITE;
            end
            S_WRITE: begin
                nxt = (count_next == len) ? S_TAIL : S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) nxt = (in_data == xsum) ? S_DONE : S_ERROR;
            end
`else
            S_FINISH: begin
                nxt = S_DONE;
            end
`endif
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready_nxt = (nxt == S_LEN_LO) || (nxt == S_LEN_HI) || (nxt == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (nxt == S_CHK) ready_nxt = 1'b1;
`endif
    end

    // Handshake and status outputs are flops loaded from the next state, so they never see in_valid combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= nxt;
            in_ready <= ready_nxt;
            mem_we   <= (nxt == S_WRITE);
            busy     <= !((nxt == S_IDLE) || (nxt == S_DONE) || (nxt == S_ERROR));
            done     <= (nxt == S_DONE);
            error    <= (nxt == S_ERROR);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len          <= '0;
            byte_cnt     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        byte_cnt     <= '0;
                        mem_addr     <= '0;
                        words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum         <= '0;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (xfer) len[7:0] <= in_data;
                end
                S_LEN_HI: begin
                    if (xfer) len[15:8] <= in_data;
                end
                S_DATA: begin
                    if (xfer) begin
                        mem_wdata[{byte_cnt, 3'b000} +: 8] <= in_data;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum <= xsum ^ in_data;
`endif
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + (ADDR_W+1)'(1);
                    // Saturate so the address never points past the last word after a full-size load.
                    if (mem_addr != ADDR_W'(DEPTH - 1)) mem_addr <= mem_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table vectors, hand-written corner sequences, and randomized loads against a stream-level model.
module tb_imem_loader;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int TMO    = 400;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]        tx_q[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    logic [31:0]       ew_q[$];
    bit                exp_done;
    bit                exp_err;
    int                exp_words;

    typedef struct packed {
        logic [3:0]       nb;
        logic [0:11][7:0] b;
        logic             e_done;
        logic             e_err;
        logic [6:0]       e_words;
        logic [31:0]      e_w0;
        logic [31:0]      e_w1;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            chk("ready_low_during_write", 32'(in_ready), 32'd0);
        end
    end

    function automatic logic [7:0] data_xor();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < tx_q.size(); i++) x ^= tx_q[i];
        return x;
    endfunction

    task automatic append_chk();
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (int'({tx_q[1], tx_q[0]}) <= DEPTH) tx_q.push_back(data_xor());
`endif
    endtask

    // Reference: what the stream should produce, from the header count and the byte layout alone.
    task automatic model();
        int len;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] xs;
        xs = 8'h00;
`endif
        len = int'({tx_q[1], tx_q[0]});
        ew_q.delete();
        if (len > DEPTH) begin
            exp_err = 1; exp_done = 0; exp_words = 0;
        end else begin
            for (int w = 0; w < len; w++) begin
                ew_q.push_back({tx_q[2+4*w+3], tx_q[2+4*w+2], tx_q[2+4*w+1], tx_q[2+4*w]});
`ifdef IMEM_LOADER_CHECKSUM_EN
                for (int k = 0; k < 4; k++) xs ^= tx_q[2+4*w+k];
`endif
            end
            exp_words = len;
`ifdef IMEM_LOADER_CHECKSUM_EN
            exp_done = (tx_q[2+4*len] == xs);
            exp_err  = !exp_done;
`else
            exp_done = 1; exp_err = 0;
`endif
        end
    endtask

    task automatic do_start();
        wa_q.delete();
        wd_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        bit got;
        t = 0; got = 0;
        in_data = b; in_valid = 1'b1;
        while (!got && t < TMO) begin
            if (in_ready === 1'b1) begin
                @(posedge clk); got = 1;
            end else begin
                @(negedge clk); t++;
            end
        end
        #1 in_valid = 1'b0;
        if (!got) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clk);
            send_byte(tx_q[i]);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < TMO) begin
            @(negedge clk); t++;
        end
        if (t >= TMO) chk("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_load(input bit gaps);
        do_start();
        send_range(0, tx_q.size(), gaps);
        wait_idle();
    endtask

    task automatic check_model(input string tag);
        model();
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_nwrites"}, 32'(wd_q.size()), 32'(ew_q.size()));
        for (int i = 0; i < wd_q.size() && i < ew_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(i));
            chk($sformatf("%s_data%0d", tag, i), wd_q[i], ew_q[i]);
        end
    endtask

    task automatic random_stream(input int len);
        tx_q.delete();
        tx_q.push_back(len[7:0]);
        tx_q.push_back(len[15:8]);
        if (len <= DEPTH)
            for (int i = 0; i < 4*len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        append_chk();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        vecs[0] = '{nb: 4'd10, b: {8'h02,8'h00,8'h13,8'h05,8'hA0,8'h00,8'h93,8'h05,8'h10,8'h00,8'h00,8'h00},
                    e_done: 1'b1, e_err: 1'b0, e_words: 7'd2, e_w0: 32'h00A00513, e_w1: 32'h00100593};
        vecs[1] = '{nb: 4'd2, b: {8'h41,8'h00,80'h0},
                    e_done: 1'b0, e_err: 1'b1, e_words: 7'd0, e_w0: 32'h0, e_w1: 32'h0};
        vecs[2] = '{nb: 4'd2, b: {8'h00,8'h00,80'h0},
                    e_done: 1'b1, e_err: 1'b0, e_words: 7'd0, e_w0: 32'h0, e_w1: 32'h0};
        vecs[3] = '{nb: 4'd6, b: {8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,48'h0},
                    e_done: 1'b1, e_err: 1'b0, e_words: 7'd1, e_w0: 32'hDEADBEEF, e_w1: 32'h0};
        vecs[4] = '{nb: 4'd2, b: {8'h00,8'h01,80'h0},
                    e_done: 1'b0, e_err: 1'b1, e_words: 7'd0, e_w0: 32'h0, e_w1: 32'h0};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            tx_q.delete();
            for (int i = 0; i < int'(vecs[v].nb); i++) tx_q.push_back(vecs[v].b[i]);
            append_chk();
            run_load(1'b0);
            chk($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].e_done));
            chk($sformatf("vec%0d_error", v), 32'(error), 32'(vecs[v].e_err));
            chk($sformatf("vec%0d_words", v), 32'(words_loaded), 32'(vecs[v].e_words));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
            chk($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'd0);
            chk($sformatf("vec%0d_nwrites", v), 32'(wd_q.size()), 32'(vecs[v].e_words));
            if (vecs[v].e_words >= 7'd1)
                chk($sformatf("vec%0d_w0", v), (wd_q.size() > 0) ? wd_q[0] : 32'h0BAD_0BAD, vecs[v].e_w0);
            if (vecs[v].e_words >= 7'd2)
                chk($sformatf("vec%0d_w1", v), (wd_q.size() > 1) ? wd_q[1] : 32'h0BAD_0BAD, vecs[v].e_w1);
        end

        // Host stalls for 3 cycles between data bytes 2 and 3; no write may appear early.
        tx_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        append_chk();
        do_start();
        send_range(0, 4, 1'b0);
        repeat (3) @(negedge clk);
        send_range(4, 5, 1'b0);
        @(negedge clk);
        chk("gap_no_early_write", 32'(wd_q.size()), 32'd0);
        send_range(5, tx_q.size(), 1'b0);
        wait_idle();
        chk("gap_w0", (wd_q.size() > 0) ? wd_q[0] : 32'h0BAD_0BAD, 32'h44332211);
        check_model("gap");

        // Reset after two of four words: outputs clear immediately, then a fresh load starts at address 0.
        random_stream(4);
        do_start();
        send_range(0, 10, 1'b0);
        for (int t = 0; t < 20 && wd_q.size() < 2; t++) @(negedge clk);
        chk("mid_rst_two_written", 32'(wd_q.size()), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_error", 32'(error), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
        chk("mid_rst_words", 32'(words_loaded), 32'd0);
        @(negedge clk); reset = 1'b0;
        random_stream(1);
        run_load(1'b0);
        check_model("after_rst");

        // start pulsed mid-load must not restart it.
        random_stream(2);
        do_start();
        send_range(0, 4, 1'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_range(4, tx_q.size(), 1'b0);
        wait_idle();
        check_model("start_in_data");

`ifdef IMEM_LOADER_CHECKSUM_EN
        tx_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        run_load(1'b0);
        chk("csum_ok_done", 32'(done), 32'd1);
        chk("csum_ok_error", 32'(error), 32'd0);
        tx_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        run_load(1'b0);
        chk("csum_bad_done", 32'(done), 32'd0);
        chk("csum_bad_error", 32'(error), 32'd1);
        chk("csum_bad_nwrites", 32'(wd_q.size()), 32'd1);
        chk("csum_bad_w0", (wd_q.size() > 0) ? wd_q[0] : 32'h0BAD_0BAD, 32'h08040201);
`endif

        // Full-depth load exercises the upper address boundary.
        random_stream(DEPTH);
        run_load(1'b0);
        check_model("full_depth");

        for (int n = 0; n < 20; n++) begin
            int r;
            int len;
            r = $urandom_range(0, 9);
            if (r == 0)      len = DEPTH + $urandom_range(1, 300);
            else if (r == 1) len = DEPTH;
            else             len = $urandom_range(0, 10);
            random_stream(len);
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (len <= DEPTH && $urandom_range(0, 3) == 0)
                tx_q[tx_q.size()-1] = tx_q[tx_q.size()-1] ^ 8'h5A;
`endif
            run_load(1'($urandom_range(0, 1)));
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
